shiftreg_deser: RTL and testbench
=================================

// Module: shiftreg_deser
// PURPOSE
//  Serial-to-parallel receiver: the far end of the parallel-load/serial-out shift register link.
//  Samples serial bit A on every clk edge where ena=1, MSB first, and assembles WIDTH-bit words.
//  Each finished word goes into a one-entry holding buffer and is presented on a valid/ready port.
//  A sync input realigns the word boundary; a sticky overrun flag reports dropped words.
// PARAMETERS
//  WIDTH   4   word width in bits; must be >= 2
// PORTS
//  clk       in   1      single clock; all state changes on the rising edge
//  clr       in   1      synchronous, active-high reset
//  ena       in   1      bit strobe: A is valid this cycle
//  A         in   1      serial data bit, MSB of each word first
//  sync      in   1      restart word assembly at a boundary (like a new load on the transmitter)
//  ready     in   1      consumer accepts data_out this cycle
//  ovr_clr   in   1      clears the sticky overrun flag
//  data_out  out  WIDTH  assembled word (held in the buffer)
//  valid     out  1      data_out holds an unconsumed word
//  overrun   out  1      sticky: a completed word was dropped
//  busy      out  1      a partial word is being assembled (FSM state SHIFT)
// BEHAVIOUR
//  - Reset (clr=1 at an edge): sr=0, cnt=0, state=IDLE, data_out=0, valid=0, overrun=0, busy=0.
//    clr has priority over every other input, including in the middle of a word.
//  - FSM states: IDLE (cnt==0) and SHIFT (0<cnt<WIDTH).
//    IDLE -> SHIFT on ena. SHIFT -> IDLE when a word completes or on sync without ena.
//    busy = (state==SHIFT).
//  - Shift: on ena, sr <= {sr[WIDTH-2:0], A} and cnt <= cnt+1. With ena=0, sr and cnt hold,
//    so gaps between bits are allowed.
//  - Completion: an ena edge with cnt==WIDTH-1. The word is w={sr[WIDTH-2:0],A}; cnt wraps to 0.
//    The word reaches the buffer at that same edge, so valid rises the cycle after the last bit.
//    The whole path has 0 cycles of extra latency.
//  - Handshake: a word is consumed at an edge where valid&ready. valid stays high until then.
//    data_out is stable while valid=1 and ready=0.
//  - Completion while the buffer is free (valid=0, or valid&ready at the same edge):
//    data_out<=w, valid<=1.
//  - Completion while the buffer is full (valid&!ready): w is dropped and data_out keeps the old word.
//    overrun<=1.
//  - overrun clears only on clr or ovr_clr. If an overrun event and ovr_clr fall on the same edge,
//    overrun stays 1.
//  - sync: sr<=0, cnt<=0, and the partial word is discarded without setting overrun.
//    sync together with ena: A becomes bit 1 of a new word (sr<={..0,A}, cnt<=1, state=SHIFT).
//    sync never changes the buffer, valid or overrun. A completion on the same edge is cancelled.
//  - Consume with no completion: valid<=0 and data_out holds its last value.
// STRUCTURE
//  - Package shiftreg_pkg: state enum {IDLE, SHIFT}, constant DEFAULT_WIDTH=4,
//    function cnt_width(WIDTH)=$clog2(WIDTH).
//  - Sub-module rx_hold_buf: one-entry valid/ready holding register (load, ready, data, valid, overrun).
//  - Top level: shift register, bit counter, FSM, sync/completion logic.
// TESTING (WIDTH=4)
//  1. clr for 1 cycle, all inputs 0 -> data_out=0000, valid=0, overrun=0, busy=0.
//  2. ready=1; ena=1 on 4 consecutive cycles with A=1,1,0,1 -> data_out=1101 and valid=1 the cycle
//     after the 4th bit; valid=0 one cycle later; busy=1 during bits 2-4.
//  3. ready=0; send 1101, then 1010 -> data_out stays 1101, overrun=1.
//     Then ready=1 for 1 cycle -> valid=0 while overrun stays 1; ovr_clr pulse -> overrun=0.
//  4. Send A=1,0; then sync+ena with A=1; then A=0,1,0 -> word 1010 is delivered and overrun=0.
//  5. ready=1 constant; 8 back-to-back ena bits 1101 then 0110 -> valid high the cycle after bit 4
//     (1101) and after bit 8 (0110); no overrun.
//     Same stimulus with ena gaps (ena=0 between every bit) gives the same words.
//  6. clr after 2 bits of a word -> busy=0; the next 4 bits 0011 give data_out=0011 with no leftover bits.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package shiftreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter width needed to count 0 .. width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/rx_hold_buf.sv
// One-entry valid/ready holding register for assembled words.
// A word offered while the entry is occupied and not being consumed is dropped
// and recorded in the sticky overrun flag.
module rx_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             ready,
  input  logic             ovr_clr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun
);

  logic consume;
  logic room;

  assign consume = valid & ready;
  assign room    = ~valid | ready;

  // Buffer entry, valid flag and sticky overrun; a drop beats ovr_clr on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load && room) begin
        data_out <= data;
        valid    <= 1'b1;
      end else if (consume) begin
        valid <= 1'b0;
      end

      if (load && !room) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shiftreg_deser.sv
// Serial-to-parallel receiver: shifts in A MSB first on each ena strobe,
// hands each finished word to a one-entry valid/ready buffer. sync restarts
// word assembly; a completion landing on a sync edge is cancelled.
module shiftreg_deser
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ena,
  input  logic             A,
  input  logic             sync,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Only the lower WIDTH-1 bits are kept: the final bit goes straight from A
  // into the completed word, so no separate MSB storage is needed.
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  state_t           state;

  logic [WIDTH-1:0] word;
  logic             complete;

  assign word     = {sr, A};
  assign complete = ena && !sync && (cnt == LAST);
  assign busy     = (state == SHIFT);

  // Shift register, bit counter and IDLE/SHIFT state; sync overrides normal shifting.
  always_ff @(posedge clk) begin
    if (clr) begin
      sr    <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else if (sync) begin
      sr <= '0;
      if (ena) begin
        sr[0] <= A;
        cnt   <= CW'(1);
        state <= SHIFT;
      end else begin
        cnt   <= '0;
        state <= IDLE;
      end
    end else if (ena) begin
      sr <= word[WIDTH-2:0];
      if (cnt == LAST) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt   <= cnt + 1'b1;
        state <= SHIFT;
      end
    end
  end

  rx_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk      (clk),
    .clr      (clr),
    .load     (complete),
    .ready    (ready),
    .ovr_clr  (ovr_clr),
    .data     (word),
    .data_out (data_out),
    .valid    (valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_shiftreg_deser.sv
// Bench for shiftreg_deser (WIDTH=4): directed bit streams, expected words
// queued at stimulus time and popped by a monitor on every valid&ready handshake.
module tb_shiftreg_deser;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr, ena, A, sync, ready, ovr_clr;
  logic [W-1:0] data_out;
  logic         valid, overrun, busy;

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] sb[$];

  shiftreg_deser #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .ena      (ena),
    .A        (A),
    .sync     (sync),
    .ready    (ready),
    .ovr_clr  (ovr_clr),
    .data_out (data_out),
    .valid    (valid),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (clr === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %b, no word expected", data_out);
      end else begin
        logic [W-1:0] exp_w;
        exp_w = sb.pop_front();
        if (data_out !== exp_w) begin
          errors++;
          $display("FAIL word_data: got %b, expected %b", data_out, exp_w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic send_bit(input logic a);
    ena = 1'b1;
    A   = a;
    step();
    ena = 1'b0;
    A   = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gap);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (gap) step();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] pair;
    clr = 1'b1; ena = 1'b0; A = 1'b0; sync = 1'b0; ready = 1'b0; ovr_clr = 1'b0;

    // 1: reset state
    step();
    clr = 1'b0;
    check("rst_data", data_out, 0);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    // 2: single word with ready high
    ready = 1'b1;
    sb.push_back(4'b1101);
    send_bit(1'b1); check("t2_busy_b2", busy, 1);
    send_bit(1'b1); check("t2_busy_b3", busy, 1);
    send_bit(1'b0); check("t2_busy_b4", busy, 1);
    send_bit(1'b1);
    check("t2_valid", valid, 1);
    check("t2_data", data_out, 4'b1101);
    check("t2_busy_done", busy, 0);
    step();
    check("t2_valid_drop", valid, 0);

    // 3: overrun while buffer is held
    ready = 1'b0;
    sb.push_back(4'b1101);
    send_word(4'b1101, 1'b0);
    send_word(4'b1010, 1'b0);
    check("t3_data_kept", data_out, 4'b1101);
    check("t3_overrun", overrun, 1);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t3_valid_consumed", valid, 0);
    check("t3_overrun_sticky", overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("t3_overrun_clr", overrun, 0);

    // 4: sync realigns the word boundary
    ready = 1'b1;
    sb.push_back(4'b1010);
    send_bit(1'b1);
    send_bit(1'b0);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    check("t4_busy_after_sync", busy, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("t4_valid", valid, 1);
    check("t4_data", data_out, 4'b1010);
    check("t4_overrun", overrun, 0);
    step();

    // 5: back-to-back words, then the same with gaps
    pair = 8'b1101_0110;
    sb.push_back(4'b1101);
    sb.push_back(4'b0110);
    for (int i = 7; i >= 0; i--) begin
      send_bit(pair[i]);
      if (i == 4) begin
        check("t5_valid_w1", valid, 1);
        check("t5_data_w1", data_out, 4'b1101);
      end
    end
    check("t5_valid_w2", valid, 1);
    check("t5_data_w2", data_out, 4'b0110);
    step();
    check("t5_overrun", overrun, 0);
    sb.push_back(4'b1101);
    sb.push_back(4'b0110);
    send_word(4'b1101, 1'b1);
    send_word(4'b0110, 1'b1);
    check("t5_gap_overrun", overrun, 0);

    // 6: clr in the middle of a word discards the partial bits
    send_bit(1'b1);
    send_bit(1'b1);
    do_clr();
    check("t6_busy", busy, 0);
    check("t6_valid", valid, 0);
    sb.push_back(4'b0011);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("t6_data", data_out, 4'b0011);
    step();

    // 7: completion and consume on the same edge, then overrun beating ovr_clr
    ready = 1'b0;
    sb.push_back(4'b1101);
    sb.push_back(4'b0110);
    send_word(4'b1101, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ready = 1'b1;
    send_bit(1'b0);
    ready = 1'b0;
    check("t7_swap_data", data_out, 4'b0110);
    check("t7_swap_valid", valid, 1);
    check("t7_swap_overrun", overrun, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    ovr_clr = 1'b1;
    send_bit(1'b1);
    ovr_clr = 1'b0;
    check("t7_ovr_priority", overrun, 1);
    check("t7_data_held", data_out, 4'b0110);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t7_valid_consumed", valid, 0);

    // every queued word must have been delivered
    repeat (3) step();
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
